// File: rtl/prim_hwupd_arb_pkg.sv
// Shared types for the hardware-update arbiter: FSM state encoding and index-width helper.
package prim_hwupd_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_REPLAY = 2'd2
    } state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 32'd1) ? int'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/prim_hwupd_rr_pick.sv
// Combinational round-robin picker: first valid index at or after ptr, wrapping modulo NREQ.
module prim_hwupd_rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            found
);

    logic [IW-1:0] k_s;

    // Scan offsets from farthest to nearest so the nearest valid requester wins.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        k_s   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            k_s   = IW'((int'(ptr) + i) % NREQ);
            found = found | valid[k_s];
            idx   = valid[k_s] ? k_s : idx;
        end
        gnt[idx] = found;
    end

endmodule

// File: rtl/prim_hwupd_arb.sv
// Round-robin sequencer sharing one field's hardware-update port; software writes win and
// collided updates are replayed when PRIM_HWUPD_ARB_REPLAY_EN is defined, otherwise dropped.
module prim_hwupd_arb
    import prim_hwupd_arb_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int DW         = 32,
    parameter int MAX_REPLAY = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NREQ-1:0]          req_valid_i,
    input  logic [NREQ*DW-1:0]       req_data_i,
    output logic [NREQ-1:0]          req_ready_o,
    input  logic                     sw_we_i,
    output logic                     de_o,
    output logic [DW-1:0]            d_o,
    output logic [$clog2(NREQ)-1:0]  gnt_idx_o,
    output logic                     commit_o,
    output logic                     drop_o
);

    localparam int IW = int'(idx_width(NREQ));

    state_e          state_r, state_s;
    logic [DW-1:0]   d_r;
    logic [IW-1:0]   idx_r, rr_ptr_r, pick_idx_s;
    logic [NREQ-1:0] pick_gnt_s;
    logic            pick_found_s, de_r, drop_r;
    logic            commit_s, collide_s, drop_s, replay_s, free_s, grant_s;

    prim_hwupd_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .valid (req_valid_i),
        .ptr   (rr_ptr_r),
        .gnt   (pick_gnt_s),
        .idx   (pick_idx_s),
        .found (pick_found_s)
    );

    assign commit_s  = de_r & ~sw_we_i;
    assign collide_s = de_r & sw_we_i;

`ifdef PRIM_HWUPD_ARB_REPLAY_EN
    localparam int CW = $clog2(MAX_REPLAY + 1);
    logic [CW-1:0] cnt_r;

    assign drop_s   = collide_s & (cnt_r == CW'(MAX_REPLAY));
    assign replay_s = collide_s & (cnt_r != CW'(MAX_REPLAY));

    // Replay counter: cleared on every grant, bumped on each re-issue.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_r <= '0;
        end else if (grant_s) begin
            cnt_r <= '0;
        end else if (replay_s) begin
            cnt_r <= cnt_r + 1'b1;
        end
    end
`else
    logic [31:0] unused_max_replay_s;

    assign unused_max_replay_s = 32'(MAX_REPLAY);
    assign drop_s   = collide_s;
    assign replay_s = 1'b0;
`endif

    // A drop or commit frees the stage in the same cycle, allowing back-to-back grants.
    assign free_s      = (state_r == ST_IDLE) | commit_s | drop_s;
    assign grant_s     = free_s & pick_found_s;
    assign req_ready_o = grant_s ? pick_gnt_s : '0;
    assign commit_o    = commit_s;

    // Next-state selection for the issue stage.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                state_s = grant_s ? ST_ISSUE : ST_IDLE;
            end
            ST_ISSUE, ST_REPLAY: begin
                if (commit_s | drop_s) begin
                    state_s = grant_s ? ST_ISSUE : ST_IDLE;
                end else if (replay_s) begin
                    state_s = ST_REPLAY;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register, registered output stage and round-robin pointer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r  <= ST_IDLE;
            de_r     <= 1'b0;
            drop_r   <= 1'b0;
            d_r      <= '0;
            idx_r    <= '0;
            rr_ptr_r <= '0;
        end else begin
            state_r <= state_s;
            de_r    <= (state_s != ST_IDLE);
            drop_r  <= drop_s;
            if (grant_s) begin
                d_r      <= req_data_i[int'(pick_idx_s)*DW +: DW];
                idx_r    <= pick_idx_s;
                rr_ptr_r <= (pick_idx_s == IW'(NREQ - 1)) ? '0 : pick_idx_s + 1'b1;
            end
        end
    end

    assign de_o      = de_r;
    assign d_o       = d_r;
    assign gnt_idx_o = idx_r;
    assign drop_o    = drop_r;

endmodule

// File: tb/tb_prim_hwupd_arb.sv
// Directed self-checking bench for prim_hwupd_arb (NREQ=4, DW=32, MAX_REPLAY=3).
module tb_prim_hwupd_arb;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic [3:0]   req_valid_i;
    logic [127:0] req_data_i;
    logic [3:0]   req_ready_o;
    logic         sw_we_i;
    logic         de_o;
    logic [31:0]  d_o;
    logic [1:0]   gnt_idx_o;
    logic         commit_o;
    logic         drop_o;

    int n_chk  = 0;
    int n_fail = 0;

    prim_hwupd_arb #(.NREQ(4), .DW(32), .MAX_REPLAY(3)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_ready_o (req_ready_o),
        .sw_we_i     (sw_we_i),
        .de_o        (de_o),
        .d_o         (d_o),
        .gnt_idx_o   (gnt_idx_o),
        .commit_o    (commit_o),
        .drop_o      (drop_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Requester i carries data 0xA5A5_0001 + i, so d_o is implied by the index.
    task automatic chk_all(input string tag, input logic e_de, input int e_idx,
                           input logic e_commit, input logic e_drop, input logic [3:0] e_ready);
        chk($sformatf("%s.de", tag), 32'(de_o), 32'(e_de));
        if (e_de) begin
            chk($sformatf("%s.d", tag), d_o, 32'hA5A5_0001 + 32'(e_idx));
            chk($sformatf("%s.idx", tag), 32'(gnt_idx_o), 32'(e_idx));
        end
        chk($sformatf("%s.commit", tag), 32'(commit_o), 32'(e_commit));
        chk($sformatf("%s.drop", tag), 32'(drop_o), 32'(e_drop));
        chk($sformatf("%s.ready", tag), 32'(req_ready_o), 32'(e_ready));
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni      = 1'b0;
        req_valid_i = 4'b0000;
        sw_we_i     = 1'b0;
        for (int i = 0; i < 4; i++) req_data_i[i*32 +: 32] = 32'hA5A5_0001 + 32'(i);
        #2;
        chk("rst.d", d_o, 32'h0);
        chk("rst.idx", 32'(gnt_idx_o), 32'h0);
        chk_all("rst", 1'b0, 0, 1'b0, 1'b0, 4'b0000);
        tick;
        rst_ni = 1'b1;

        // Single requester
        req_valid_i = 4'b0001; #1;
        chk_all("single.t", 1'b0, 0, 1'b0, 1'b0, 4'b0001);
        tick; req_valid_i = 4'b0000; #1;
        chk_all("single.t1", 1'b1, 0, 1'b1, 1'b0, 4'b0000);
        tick; #1;
        chk_all("single.t2", 1'b0, 0, 1'b0, 1'b0, 4'b0000);

        // All valid, pointer starts at 1: grants 1,2,3,0,1 back-to-back
        req_valid_i = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (k == 0) chk_all("rr.c0", 1'b0, 0, 1'b0, 1'b0, 4'b0010);
            else chk_all($sformatf("rr.c%0d", k), 1'b1, k % 4, 1'b1, 1'b0, 4'(1 << ((1 + k) % 4)));
            tick;
        end
        req_valid_i = 4'b0000; #1;
        chk_all("rr.c5", 1'b1, 1, 1'b1, 1'b0, 4'b0000);
        tick; #1;
        chk_all("rr.c6", 1'b0, 0, 1'b0, 1'b0, 4'b0000);

        // Requester 2 collides in its first de cycles; pointer is 2
        req_valid_i = 4'b0100; #1;
        chk_all("col.t", 1'b0, 0, 1'b0, 1'b0, 4'b0100);
        tick; req_valid_i = 4'b0000; sw_we_i = 1'b1; #1;
        chk_all("col.t1", 1'b1, 2, 1'b0, 1'b0, 4'b0000);
`ifdef PRIM_HWUPD_ARB_REPLAY_EN
        tick; #1;
        chk_all("col.t2", 1'b1, 2, 1'b0, 1'b0, 4'b0000);
        tick; sw_we_i = 1'b0; #1;
        chk_all("col.t3", 1'b1, 2, 1'b1, 1'b0, 4'b0000);
        tick; #1;
        chk_all("col.t4", 1'b0, 0, 1'b0, 1'b0, 4'b0000);
`else
        tick; sw_we_i = 1'b0; #1;
        chk_all("col.t2", 1'b0, 0, 1'b0, 1'b1, 4'b0000);
        tick; #1;
        chk_all("col.t3", 1'b0, 0, 1'b0, 1'b0, 4'b0000);
`endif

        // Software write held six cycles, requesters 0 and 1 pending; pointer is 3
        req_valid_i = 4'b0011; sw_we_i = 1'b1; #1;
        chk_all("hold.t", 1'b0, 0, 1'b0, 1'b0, 4'b0001);
`ifdef PRIM_HWUPD_ARB_REPLAY_EN
        tick; #1; chk_all("hold.t1", 1'b1, 0, 1'b0, 1'b0, 4'b0000);
        tick; #1; chk_all("hold.t2", 1'b1, 0, 1'b0, 1'b0, 4'b0000);
        tick; #1; chk_all("hold.t3", 1'b1, 0, 1'b0, 1'b0, 4'b0000);
        tick; #1; chk_all("hold.t4", 1'b1, 0, 1'b0, 1'b0, 4'b0010);
        tick; #1; chk_all("hold.t5", 1'b1, 1, 1'b0, 1'b1, 4'b0000);
        tick; sw_we_i = 1'b0; #1;
        chk_all("hold.t6", 1'b1, 1, 1'b1, 1'b0, 4'b0001);
`else
        tick; #1; chk_all("hold.t1", 1'b1, 0, 1'b0, 1'b0, 4'b0010);
        tick; #1; chk_all("hold.t2", 1'b1, 1, 1'b0, 1'b1, 4'b0001);
        tick; #1; chk_all("hold.t3", 1'b1, 0, 1'b0, 1'b1, 4'b0010);
        tick; #1; chk_all("hold.t4", 1'b1, 1, 1'b0, 1'b1, 4'b0001);
        tick; #1; chk_all("hold.t5", 1'b1, 0, 1'b0, 1'b1, 4'b0010);
        tick; sw_we_i = 1'b0; #1;
        chk_all("hold.t6", 1'b1, 1, 1'b1, 1'b1, 4'b0001);
`endif
        tick; req_valid_i = 4'b0000; #1;
        chk_all("hold.t7", 1'b1, 0, 1'b1, 1'b0, 4'b0000);
        tick; #1;
        chk_all("hold.t8", 1'b0, 0, 1'b0, 1'b0, 4'b0000);

        // Reset in the middle of an update; pointer is 1 so requester 2 is picked
        req_valid_i = 4'b0100; #1;
        chk_all("mrst.t", 1'b0, 0, 1'b0, 1'b0, 4'b0100);
        tick; req_valid_i = 4'b0000; sw_we_i = 1'b1; #1;
        chk_all("mrst.t1", 1'b1, 2, 1'b0, 1'b0, 4'b0000);
`ifdef PRIM_HWUPD_ARB_REPLAY_EN
        tick; #1;
        chk_all("mrst.t2", 1'b1, 2, 1'b0, 1'b0, 4'b0000);
`endif
        rst_ni = 1'b0; #1;
        chk("mrst.async.d", d_o, 32'h0);
        chk("mrst.async.idx", 32'(gnt_idx_o), 32'h0);
        chk_all("mrst.async", 1'b0, 0, 1'b0, 1'b0, 4'b0000);
        tick;
        chk_all("mrst.held", 1'b0, 0, 1'b0, 1'b0, 4'b0000);
        sw_we_i = 1'b0; rst_ni = 1'b1; req_valid_i = 4'b1111; #1;
        chk_all("mrst.rel", 1'b0, 0, 1'b0, 1'b0, 4'b0001);
        tick; req_valid_i = 4'b0000; #1;
        chk_all("mrst.rel1", 1'b1, 0, 1'b1, 1'b0, 4'b0000);
        tick; #1;
        chk_all("mrst.rel2", 1'b0, 0, 1'b0, 1'b0, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
